// File: rtl/coprocessor0_timer_interrupt_if.sv
// coprocessor0_timer_interrupt_if: WB-stage to CP0 signal bundle
// master (WB/exception logic): drives MTC0 write, exception/ERET events and hardware interrupts;
//   receives read_data, epc_out, interrupt_pending, timer_interrupt
// slave (CP0): the reverse directions
interface coprocessor0_timer_interrupt_if #(
  parameter int DATA_WIDTH = 32,
  parameter int HW_INT_COUNT = 5
);
  logic write_enabled;
  logic [4:0] address_register;
  logic [2:0] address_select;
  logic [DATA_WIDTH-1:0] write_data;
  logic exception_valid;
  logic [4:0] exception_code;
  logic [DATA_WIDTH-1:0] exception_pc;
  logic exception_in_delay_slot;
  logic bad_vaddr_valid;
  logic [DATA_WIDTH-1:0] bad_vaddr;
  logic eret_flush;
  logic [HW_INT_COUNT-1:0] hardware_interrupt;
  logic [DATA_WIDTH-1:0] read_data;
  logic [DATA_WIDTH-1:0] epc_out;
  logic interrupt_pending;
  logic timer_interrupt;
  modport master (
    output write_enabled, address_register, address_select, write_data,
    output exception_valid, exception_code, exception_pc, exception_in_delay_slot,
    output bad_vaddr_valid, bad_vaddr, eret_flush, hardware_interrupt,
    input read_data, epc_out, interrupt_pending, timer_interrupt
  );
  modport slave (
    input write_enabled, address_register, address_select, write_data,
    input exception_valid, exception_code, exception_pc, exception_in_delay_slot,
    input bad_vaddr_valid, bad_vaddr, eret_flush, hardware_interrupt,
    output read_data, epc_out, interrupt_pending, timer_interrupt
  );
endinterface

// File: rtl/coprocessor0_timer_interrupt.sv
// coprocessor0_timer_interrupt: MIPS CP0 register file with Count/Compare timer, interrupts and exception sequencing
// clock, reset : core clock, synchronous active-high reset
// cp0 (slave)  : MTC0 write / MFC0 read port, exception and ERET events, hardware interrupt lines,
//                EPC for ERET redirection, interrupt request and Cause.TI
module coprocessor0_timer_interrupt #(
  parameter int DATA_WIDTH = 32,
  parameter int HW_INT_COUNT = 5,
  parameter int COUNT_DIVIDE = 2
) (
  input logic clock,
  input logic reset,
  coprocessor0_timer_interrupt_if.slave cp0
);
  localparam int DIV_W = COUNT_DIVIDE > 1 ? $clog2(COUNT_DIVIDE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIVIDE - 1);
  logic [DIV_W-1:0] div_q;
  logic [DATA_WIDTH-1:0] count_q, compare_q, epc_q, badvaddr_q;
  logic [7:0] im_q;
  logic exl_q, ie_q, bd_q, ti_q;
  logic [1:0] sw_ip_q;
  logic [5:0] hw_ip_q, hw_ext;
  logic [4:0] exc_code_q;
  logic [7:0] ip;
  logic [DATA_WIDTH-1:0] status, cause, rd;
  logic wr_en, wr_count, wr_compare, wr_status, wr_cause, wr_epc, tick;
  // An MTC0 in the same cycle as a committed exception is discarded.
  assign wr_en = cp0.write_enabled & ~cp0.exception_valid & (cp0.address_select == 3'd0);
  assign wr_count = wr_en & (cp0.address_register == 5'd9);
  assign wr_compare = wr_en & (cp0.address_register == 5'd11);
  assign wr_status = wr_en & (cp0.address_register == 5'd12);
  assign wr_cause = wr_en & (cp0.address_register == 5'd13);
  assign wr_epc = wr_en & (cp0.address_register == 5'd14);
  assign tick = div_q == DIV_LAST;
  // Hardware lines zero-extended to six so absent lines read as 0 in IP[7:2].
  always_comb begin
    hw_ext = '0;
    hw_ext[HW_INT_COUNT-1:0] = cp0.hardware_interrupt;
  end
  assign ip = {hw_ip_q[5] | ti_q, hw_ip_q[4:0], sw_ip_q};
  assign status = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause = {bd_q, ti_q, 14'd0, ip, 1'b0, exc_code_q, 2'd0};
  always_comb begin
    rd = '0;
    if (cp0.address_select == 3'd0)
      case (cp0.address_register)
        5'd8: rd = badvaddr_q;
        5'd9: rd = count_q;
        5'd11: rd = compare_q;
        5'd12: rd = status;
        5'd13: rd = cause;
        5'd14: rd = epc_q;
        default: rd = '0;
      endcase
  end
  assign cp0.read_data = rd;
  assign cp0.epc_out = epc_q;
  assign cp0.interrupt_pending = ie_q & ~exl_q & |(ip & im_q);
  assign cp0.timer_interrupt = ti_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
      count_q <= '0;
    end else if (wr_count) begin
      div_q <= '0;
      count_q <= cp0.write_data;
    end else if (tick) begin
      div_q <= '0;
      count_q <= count_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end
  // Writing Compare acknowledges the timer and beats a coincident match.
  always_ff @(posedge clock) begin
    if (reset) begin
      compare_q <= '0;
      ti_q <= 1'b0;
    end else begin
      if (wr_compare) compare_q <= cp0.write_data;
      ti_q <= wr_compare ? 1'b0 : (count_q == compare_q) ? 1'b1 : ti_q;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      im_q <= '0;
      ie_q <= 1'b0;
      exl_q <= 1'b0;
    end else begin
      exl_q <= cp0.exception_valid ? 1'b1 : cp0.eret_flush ? 1'b0 : wr_status ? cp0.write_data[1] : exl_q;
      if (wr_status) begin
        im_q <= cp0.write_data[15:8];
        ie_q <= cp0.write_data[0];
      end
    end
  end
  // EPC/BD only capture the first exception; a nested one keeps the original return point.
  always_ff @(posedge clock) begin
    if (reset) begin
      epc_q <= '0;
      bd_q <= 1'b0;
      exc_code_q <= '0;
      badvaddr_q <= '0;
    end else if (cp0.exception_valid) begin
      exc_code_q <= cp0.exception_code;
      if (!exl_q) begin
        epc_q <= cp0.exception_in_delay_slot ? cp0.exception_pc - DATA_WIDTH'(4) : cp0.exception_pc;
        bd_q <= cp0.exception_in_delay_slot;
      end
      if (cp0.bad_vaddr_valid) badvaddr_q <= cp0.bad_vaddr;
    end else if (wr_epc) begin
      epc_q <= cp0.write_data;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_ip_q <= '0;
      hw_ip_q <= '0;
    end else begin
      hw_ip_q <= hw_ext;
      if (wr_cause) sw_ip_q <= cp0.write_data[9:8];
    end
  end
endmodule

// File: tb/tb_coprocessor0_timer_interrupt.sv
// tb_coprocessor0_timer_interrupt: directed self-checking bench for the CP0 timer/interrupt block
module tb_coprocessor0_timer_interrupt;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  coprocessor0_timer_interrupt_if #(.DATA_WIDTH(32), .HW_INT_COUNT(5)) bus ();
  coprocessor0_timer_interrupt #(.DATA_WIDTH(32), .HW_INT_COUNT(5), .COUNT_DIVIDE(2)) dut (
    .clock(clock),
    .reset(reset),
    .cp0(bus)
  );
  always #5 clock = ~clock;
  task automatic rd(input logic [4:0] r, input logic [2:0] s, output logic [31:0] v);
    bus.address_register = r;
    bus.address_select = s;
    #1;
    v = bus.read_data;
  endtask
  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    bus.write_enabled = 1'b1;
    bus.address_register = r;
    bus.address_select = 3'd0;
    bus.write_data = d;
    @(posedge clock);
    #1;
    bus.write_enabled = 1'b0;
  endtask
  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic ds, input logic bvv, input logic [31:0] bv);
    bus.exception_valid = 1'b1;
    bus.exception_code = code;
    bus.exception_pc = pc;
    bus.exception_in_delay_slot = ds;
    bus.bad_vaddr_valid = bvv;
    bus.bad_vaddr = bv;
    @(posedge clock);
    #1;
    bus.exception_valid = 1'b0;
    bus.bad_vaddr_valid = 1'b0;
  endtask
  task automatic eret();
    bus.eret_flush = 1'b1;
    @(posedge clock);
    #1;
    bus.eret_flush = 1'b0;
  endtask
  task automatic test_reset();
    logic [31:0] v;
    repeat (2) @(posedge clock);
    #1;
    rd(5'd12, 3'd0, v);
    checks++; if (v !== 32'h0040_0000) begin errors++; $display("FAIL reset_status: got %h want %h", v, 32'h0040_0000); end
    rd(5'd13, 3'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h want 0", v); end
    rd(5'd9, 3'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want 0", v); end
    checks++; if (bus.epc_out !== 32'h0) begin errors++; $display("FAIL reset_epc_out: got %h want 0", bus.epc_out); end
    checks++; if (bus.interrupt_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", bus.interrupt_pending); end
    checks++; if (bus.timer_interrupt !== 1'b0) begin errors++; $display("FAIL reset_ti: got %b want 0", bus.timer_interrupt); end
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask
  task automatic test_count_wrap();
    logic [31:0] v;
    mtc0(5'd9, 32'hFFFF_FFFE);
    repeat (4) @(posedge clock);
    #1;
    rd(5'd9, 3'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL count_wrap: got %h want 0", v); end
  endtask
  task automatic test_timer();
    logic [31:0] v;
    bit hit = 1'b0;
    mtc0(5'd11, 32'd3);
    for (int i = 0; i < 20 && !hit; i++) begin
      rd(5'd9, 3'd0, v);
      if (v == 32'd3) hit = 1'b1;
      else begin
        @(posedge clock);
        #1;
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL timer_reach: count %h never reached 3", v); end
    checks++; if (bus.timer_interrupt !== 1'b0) begin errors++; $display("FAIL timer_early: got %b want 0", bus.timer_interrupt); end
    @(posedge clock);
    #1;
    checks++; if (bus.timer_interrupt !== 1'b1) begin errors++; $display("FAIL timer_set: got %b want 1", bus.timer_interrupt); end
    rd(5'd13, 3'd0, v);
    checks++; if (v !== 32'h4000_8000) begin errors++; $display("FAIL timer_cause: got %h want %h", v, 32'h4000_8000); end
    mtc0(5'd11, 32'h10);
    checks++; if (bus.timer_interrupt !== 1'b0) begin errors++; $display("FAIL timer_clear: got %b want 0", bus.timer_interrupt); end
  endtask
  task automatic test_interrupt();
    logic [31:0] v;
    mtc0(5'd11, 32'hFFFF_0000);
    mtc0(5'd12, 32'h0000_0401);
    bus.hardware_interrupt = 5'b00001;
    #1;
    checks++; if (bus.interrupt_pending !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b want 0", bus.interrupt_pending); end
    @(posedge clock);
    #1;
    rd(5'd13, 3'd0, v);
    checks++; if (v !== 32'h0000_0400) begin errors++; $display("FAIL irq_cause: got %h want %h", v, 32'h0000_0400); end
    checks++; if (bus.interrupt_pending !== 1'b1) begin errors++; $display("FAIL irq_pending: got %b want 1", bus.interrupt_pending); end
    exc(5'd0, 32'h40, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.interrupt_pending !== 1'b0) begin errors++; $display("FAIL irq_exl_mask: got %b want 0", bus.interrupt_pending); end
    bus.hardware_interrupt = 5'b0;
    eret();
    mtc0(5'd12, 32'h0);
    rd(5'd12, 3'd0, v);
    checks++; if (v !== 32'h0040_0000) begin errors++; $display("FAIL irq_status_clr: got %h want %h", v, 32'h0040_0000); end
  endtask
  task automatic test_exception();
    logic [31:0] v;
    exc(5'd4, 32'hBFC0_0100, 1'b1, 1'b1, 32'h1234_5679);
    rd(5'd14, 3'd0, v);
    checks++; if (v !== 32'hBFC0_00FC) begin errors++; $display("FAIL exc_epc: got %h want %h", v, 32'hBFC0_00FC); end
    rd(5'd13, 3'd0, v);
    checks++; if (v !== 32'h8000_0010) begin errors++; $display("FAIL exc_cause: got %h want %h", v, 32'h8000_0010); end
    rd(5'd8, 3'd0, v);
    checks++; if (v !== 32'h1234_5679) begin errors++; $display("FAIL exc_badvaddr: got %h want %h", v, 32'h1234_5679); end
    rd(5'd12, 3'd0, v);
    checks++; if (v !== 32'h0040_0002) begin errors++; $display("FAIL exc_status: got %h want %h", v, 32'h0040_0002); end
    checks++; if (bus.epc_out !== 32'hBFC0_00FC) begin errors++; $display("FAIL exc_epc_out: got %h want %h", bus.epc_out, 32'hBFC0_00FC); end
  endtask
  task automatic test_nested();
    logic [31:0] v;
    exc(5'd5, 32'h8000_0000, 1'b0, 1'b0, 32'hAAAA_AAAA);
    rd(5'd14, 3'd0, v);
    checks++; if (v !== 32'hBFC0_00FC) begin errors++; $display("FAIL nest_epc: got %h want %h", v, 32'hBFC0_00FC); end
    rd(5'd13, 3'd0, v);
    checks++; if (v !== 32'h8000_0014) begin errors++; $display("FAIL nest_cause: got %h want %h", v, 32'h8000_0014); end
    rd(5'd8, 3'd0, v);
    checks++; if (v !== 32'h1234_5679) begin errors++; $display("FAIL nest_badvaddr: got %h want %h", v, 32'h1234_5679); end
    bus.eret_flush = 1'b1;
    #1;
    checks++; if (bus.epc_out !== 32'hBFC0_00FC) begin errors++; $display("FAIL eret_epc_out: got %h want %h", bus.epc_out, 32'hBFC0_00FC); end
    @(posedge clock);
    #1;
    bus.eret_flush = 1'b0;
    rd(5'd12, 3'd0, v);
    checks++; if (v !== 32'h0040_0000) begin errors++; $display("FAIL eret_status: got %h want %h", v, 32'h0040_0000); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] v;
    bus.write_enabled = 1'b1;
    bus.address_register = 5'd14;
    bus.address_select = 3'd0;
    bus.write_data = 32'hDEAD_BEEF;
    exc(5'd8, 32'h100, 1'b0, 1'b0, 32'h0);
    bus.write_enabled = 1'b0;
    rd(5'd14, 3'd0, v);
    checks++; if (v !== 32'h100) begin errors++; $display("FAIL collide_epc: got %h want %h", v, 32'h100); end
    rd(5'd12, 3'd0, v);
    checks++; if (v !== 32'h0040_0002) begin errors++; $display("FAIL collide_status: got %h want %h", v, 32'h0040_0002); end
    eret();
    bus.eret_flush = 1'b1;
    exc(5'd8, 32'h200, 1'b0, 1'b0, 32'h0);
    bus.eret_flush = 1'b0;
    rd(5'd12, 3'd0, v);
    checks++; if (v !== 32'h0040_0002) begin errors++; $display("FAIL exc_eret_status: got %h want %h", v, 32'h0040_0002); end
    rd(5'd14, 3'd0, v);
    checks++; if (v !== 32'h200) begin errors++; $display("FAIL exc_eret_epc: got %h want %h", v, 32'h200); end
  endtask
  task automatic test_sw_fields();
    logic [31:0] v;
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 3'd0, v);
    checks++; if (v !== 32'h0000_0320) begin errors++; $display("FAIL cause_wmask: got %h want %h", v, 32'h0000_0320); end
    mtc0(5'd8, 32'h0);
    rd(5'd8, 3'd0, v);
    checks++; if (v !== 32'h1234_5679) begin errors++; $display("FAIL badvaddr_ro: got %h want %h", v, 32'h1234_5679); end
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, 3'd0, v);
    checks++; if (v !== 32'h0040_FF03) begin errors++; $display("FAIL status_wmask: got %h want %h", v, 32'h0040_FF03); end
    checks++; if (bus.interrupt_pending !== 1'b0) begin errors++; $display("FAIL sw_exl_mask: got %b want 0", bus.interrupt_pending); end
    mtc0(5'd12, 32'h0000_0101);
    checks++; if (bus.interrupt_pending !== 1'b1) begin errors++; $display("FAIL sw_pending: got %b want 1", bus.interrupt_pending); end
    rd(5'd10, 3'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_reg: got %h want 0", v); end
    rd(5'd12, 3'd1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL nonzero_sel: got %h want 0", v); end
  endtask
  task automatic test_reset_mid();
    logic [31:0] v;
    reset = 1'b1;
    @(posedge clock);
    #1;
    rd(5'd9, 3'd0, v);
    checks++; if (v > 32'd1) begin errors++; $display("FAIL mid_count: got %h want 0", v); end
    rd(5'd13, 3'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_cause: got %h want 0", v); end
    rd(5'd8, 3'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_badvaddr: got %h want 0", v); end
    checks++; if (bus.epc_out !== 32'h0) begin errors++; $display("FAIL mid_epc: got %h want 0", bus.epc_out); end
    checks++; if (bus.interrupt_pending !== 1'b0) begin errors++; $display("FAIL mid_pending: got %b want 0", bus.interrupt_pending); end
    @(posedge clock);
    #1;
    rd(5'd9, 3'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_count_held: got %h want 0", v); end
    reset = 1'b0;
  endtask
  initial begin
    bus.write_enabled = 1'b0;
    bus.address_register = '0;
    bus.address_select = '0;
    bus.write_data = '0;
    bus.exception_valid = 1'b0;
    bus.exception_code = '0;
    bus.exception_pc = '0;
    bus.exception_in_delay_slot = 1'b0;
    bus.bad_vaddr_valid = 1'b0;
    bus.bad_vaddr = '0;
    bus.eret_flush = 1'b0;
    bus.hardware_interrupt = '0;
    test_reset();
    test_count_wrap();
    test_timer();
    test_interrupt();
    test_exception();
    test_nested();
    test_back_to_back();
    test_sw_fields();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
